// File: rtl/blit_addr_pkg.sv
// Shared types and defaults for the blitter address queue.
// Holds the queued entry layout, default geometry and the occupancy-width helper.
// No logic; imported by blit_addr_fifo and blit_addr_queue.
package blit_addr_pkg;

    localparam int BLIT_DEPTH    = 4;   // queue entries, power of two 2..16
    localparam int BLIT_AW       = 24;  // address width
    localparam int BLIT_PAGE_LSB = 11;  // lowest bit of the DRAM row field

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int blit_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int BLIT_CW = blit_cw(BLIT_DEPTH);

    typedef struct packed {
        logic [BLIT_AW-1:0] address;
        logic [2:0]         pixa;
        logic               write;
        logic               zaddr;
    } blit_addr_ent_t;

endpackage

// File: rtl/blit_addr_fifo.sv
// Generic first-word-fall-through FIFO of blit_addr_ent_t.
// Latency: an entry written at edge N is visible on rd_data after edge N.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
//
// Ports: clk/rst (async active-high); push + wr_data; pop; flush;
//        rd_data (head), count (0..DEPTH), empty, full.
module blit_addr_fifo
    import blit_addr_pkg::*;
#(
    parameter int DEPTH = BLIT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  blit_addr_ent_t              wr_data,
    input  logic                        pop,
    input  logic                        flush,
    output blit_addr_ent_t              rd_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty,
    output logic                        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    blit_addr_ent_t mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage is reset so the head reads as all-zero out of reset.
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/blit_addr_queue.sv
// Address queue between blitter address generation and the memory controller.
// Latency: push at edge N gives mem_req and head fields after edge N (1 cycle min).
// Backpressure: in_ready drops when DEPTH entries are held; head holds until mem_ack.
//
// Ports: sys_clk, reset (async active-high); in_valid/in_ready with in_address,
//        in_pixa, in_write, in_zaddr; flush; mem_req/mem_ack with mem_address,
//        mem_pixa, mem_write, mem_zaddr, mem_newpage; count, idle.
// Build option BLIT_ADDR_PAGECHK_EN: track the DRAM row of the last popped entry
// and drive mem_newpage from it; otherwise mem_newpage is constant 1.
module blit_addr_queue
    import blit_addr_pkg::*;
#(
    parameter int DEPTH    = BLIT_DEPTH,
    parameter int AW       = BLIT_AW,
    parameter int PAGE_LSB = BLIT_PAGE_LSB
) (
    input  logic                        sys_clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [AW-1:0]               in_address,
    input  logic [2:0]                  in_pixa,
    input  logic                        in_write,
    input  logic                        in_zaddr,
    input  logic                        flush,
    output logic                        mem_req,
    input  logic                        mem_ack,
    output logic [AW-1:0]               mem_address,
    output logic [2:0]                  mem_pixa,
    output logic                        mem_write,
    output logic                        mem_zaddr,
    output logic                        mem_newpage,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        idle
);

    // Geometry sanity; the entry struct is sized by the package address width.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("blit_addr_queue: DEPTH must be a power of two in 2..16");
    end
    if (AW != BLIT_AW || PAGE_LSB < 0 || PAGE_LSB >= AW) begin : g_bad_geom
        $error("blit_addr_queue: AW must match the package, PAGE_LSB must be inside AW");
    end

    blit_addr_ent_t wr_ent;
    blit_addr_ent_t head;
    logic           push;
    logic           pop;
    logic           empty;
    logic           full;

    assign wr_ent.address = in_address;
    assign wr_ent.pixa    = in_pixa;
    assign wr_ent.write   = in_write;
    assign wr_ent.zaddr   = in_zaddr;

    // All handshake outputs come from FIFO state, never from the inputs.
    assign in_ready = ~full;
    assign mem_req  = ~empty;
    assign idle     = empty;
    assign push     = in_valid & in_ready;
    assign pop      = mem_req & mem_ack;

    blit_addr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (sys_clk),
        .rst     (reset),
        .push    (push),
        .wr_data (wr_ent),
        .pop     (pop),
        .flush   (flush),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    assign mem_address = head.address;
    assign mem_pixa    = head.pixa;
    assign mem_write   = head.write;
    assign mem_zaddr   = head.zaddr;

`ifdef BLIT_ADDR_PAGECHK_EN
    logic                     page_valid;
    logic [AW-PAGE_LSB-1:0]   last_page;

    // Row of the most recently completed cycle; a flush forgets it so the
    // next issued cycle always opens a fresh row.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            page_valid <= 1'b0;
            last_page  <= '0;
        end else if (flush) begin
            page_valid <= 1'b0;
        end else if (pop) begin
            page_valid <= 1'b1;
            last_page  <= head.address[AW-1:PAGE_LSB];
        end
    end

    assign mem_newpage = ~page_valid | (mem_address[AW-1:PAGE_LSB] != last_page);
`else
    assign mem_newpage = 1'b1;
`endif

endmodule

// File: tb/tb_blit_addr_queue.sv
// Self-checking bench for blit_addr_queue: queue-based reference model checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_blit_addr_queue;
    import blit_addr_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 24;
`ifdef BLIT_ADDR_PAGECHK_EN
    localparam logic NP_SAME_PAGE = 1'b0;
`else
    localparam logic NP_SAME_PAGE = 1'b1;
`endif

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_address = '0;
    logic [2:0]    in_pixa = '0;
    logic          in_write = 1'b0;
    logic          in_zaddr = 1'b0;
    logic          flush = 1'b0;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] mem_address;
    logic [2:0]    mem_pixa;
    logic          mem_write;
    logic          mem_zaddr;
    logic          mem_newpage;
    logic [2:0]    count;
    logic          idle;

    blit_addr_queue #(.DEPTH(DEPTH), .AW(AW), .PAGE_LSB(11)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_address  (in_address),
        .in_pixa     (in_pixa),
        .in_write    (in_write),
        .in_zaddr    (in_zaddr),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_address (mem_address),
        .mem_pixa    (mem_pixa),
        .mem_write   (mem_write),
        .mem_zaddr   (mem_zaddr),
        .mem_newpage (mem_newpage),
        .count       (count),
        .idle        (idle)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries plus the row of the last pop.
    blit_addr_ent_t mq[$];
    blit_addr_ent_t m_ent;
    bit             m_pv;
    int             m_last;
    bit             m_push;
    bit             m_pop;

    always @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_pv   = 1'b0;
            m_last = 0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = mem_ack && (mq.size() > 0);
            if (flush) begin
                mq.delete();
                m_pv = 1'b0;
            end else begin
                if (m_pop) begin
                    m_last = int'(mq[0].address >> 11);
                    m_pv   = 1'b1;
                    void'(mq.pop_front());
                end
                if (m_push) begin
                    m_ent.address = in_address;
                    m_ent.pixa    = in_pixa;
                    m_ent.write   = in_write;
                    m_ent.zaddr   = in_zaddr;
                    mq.push_back(m_ent);
                end
            end
        end
    end

    logic exp_np;
    always @(negedge sys_clk) begin
        chk("req", mem_req, 32'(mq.size() != 0));
        chk("count", count, 32'(mq.size()));
        chk("in_ready", in_ready, 32'(mq.size() != DEPTH));
        chk("idle", idle, 32'(mq.size() == 0));
        if (mq.size() > 0) begin
            chk("head_addr", mem_address, mq[0].address);
            chk("head_pixa", mem_pixa, mq[0].pixa);
            chk("head_write", mem_write, mq[0].write);
            chk("head_zaddr", mem_zaddr, mq[0].zaddr);
`ifdef BLIT_ADDR_PAGECHK_EN
            exp_np = !m_pv || (int'(mq[0].address >> 11) != m_last);
`else
            exp_np = 1'b1;
`endif
            chk("newpage", mem_newpage, exp_np);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_ent(input logic [AW-1:0] a, input logic [2:0] p,
                            input logic w, input logic z);
        in_valid   = 1'b1;
        in_address = a;
        in_pixa    = p;
        in_write   = w;
        in_zaddr   = z;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_newpage", mem_newpage, 1);
        chk("rst_addr", mem_address, 0);
        chk("rst_pixa", mem_pixa, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_zaddr", mem_zaddr, 0);
        reset = 1'b0;
        step();

        // 1: single push, first-word fall-through
        push_ent(24'h001000, 3'd3, 1'b1, 1'b0);
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_address, 32'h001000);
        chk("t1_pixa", mem_pixa, 3);
        chk("t1_write", mem_write, 1);
        chk("t1_count", count, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t1_flushed", count, 0);

        // 2: fill to DEPTH, extra push dropped, one pop reopens the input
        for (int i = 0; i < 4; i++) begin
            push_ent(24'h002000 + 24'(i * 16), 3'(i), 1'b0, 1'(i));
        end
        chk("t2_full_count", count, 4);
        chk("t2_full_ready", in_ready, 0);
        push_ent(24'hDEAD00, 3'd7, 1'b1, 1'b1);
        chk("t2_drop_count", count, 4);
        chk("t2_drop_head", mem_address, 32'h002000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t2_ready_back", in_ready, 1);
        chk("t2_count", count, 3);
        chk("t2_head2", mem_address, 32'h002010);
        chk("t2_head2_z", mem_zaddr, 1);
        mem_ack = 1'b1;
        repeat (3) step();
        chk("t2_last_pop_idle", idle, 1);
        mem_ack = 1'b0;

        // 3: streaming push+pop each cycle, order preserved, count steady
        push_ent(24'h000100, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            in_valid   = 1'b1;
            in_address = 24'h000100 + 24'(i * 8);
            in_pixa    = 3'(i);
            mem_ack    = 1'b1;
            step();
            chk("t3_count", count, 1);
            chk("t3_head", mem_address, 32'h000100 + 32'(i * 8));
        end
        in_valid = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("t3_drained", idle, 1);

        // 4: flush with a coincident ack
        for (int i = 0; i < 3; i++) begin
            push_ent(24'h004000 + 24'(i * 4), 3'd1, 1'b1, 1'b0);
        end
        chk("t4_count3", count, 3);
        flush   = 1'b1;
        mem_ack = 1'b1;
        step();
        flush   = 1'b0;
        mem_ack = 1'b0;
        chk("t4_count", count, 0);
        chk("t4_req", mem_req, 0);
        chk("t4_idle", idle, 1);

        // 5: page-change flag
        push_ent(24'h000800, 3'd0, 1'b0, 1'b0);
        push_ent(24'h0007F8, 3'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t5_cross_page", mem_newpage, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        push_ent(24'h000800, 3'd0, 1'b0, 1'b0);
        push_ent(24'h000810, 3'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t5_same_page", mem_newpage, NP_SAME_PAGE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_ent(24'h000810, 3'd0, 1'b0, 1'b0);
        chk("t5_after_flush", mem_newpage, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;

        // 6: async reset with an outstanding request
        push_ent(24'h003000, 3'd1, 1'b0, 1'b1);
        push_ent(24'h003008, 3'd2, 1'b1, 1'b0);
        chk("t6_count2", count, 2);
        chk("t6_req1", mem_req, 1);
        reset = 1'b1;
        #2;
        chk("t6_req", mem_req, 0);
        chk("t6_count", count, 0);
        chk("t6_ready", in_ready, 1);
        step();
        reset = 1'b0;
        step();
        push_ent(24'h005000, 3'd5, 1'b1, 1'b1);
        chk("t6_restart_addr", mem_address, 32'h005000);
        chk("t6_restart_count", count, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
